conv_mac_engine: RTL and testbench

- Consumes the image buffer (`img_data`) and the four filter buffers (`filters`) filled by the memory reader datapath.
- Computes a strided 2-D valid convolution of the image with each filter in turn, using one multiply-accumulate (MAC) per clock.
- Emits each result word through a valid/ready handshake to the downstream result writer.
- Sits directly after the memory reader, started by the top-level controller once all buffers are loaded.

---
 rtl/conv_mac_engine.sv | 167 ++++++++++++++++
 tb/tb_conv_mac_engine.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_mac_engine.sv
`timescale 1ns/1ps
// conv_mac_engine: strided 2-D valid convolution of an 8-bit image with
// NUM_FILTERS 8-bit filters, one multiply-accumulate per clock. Each finished
// window sum is presented on a registered valid/ready result port.
// Optional build macro: CONV_SATURATE_EN clamps res_data to 255 (the
// accumulator itself stays full width).
module conv_mac_engine #(
  parameter int IMG_SIZE    = 16,
  parameter int FILTER_SIZE = 4,
  parameter int NUM_FILTERS = 4,
  parameter int STRIDE      = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  img_data [IMG_SIZE*IMG_SIZE],
  input  logic [7:0]  filters  [NUM_FILTERS][FILTER_SIZE*FILTER_SIZE],
  input  logic        res_ready,
  output logic        res_valid,
  output logic [19:0] res_data,
  output logic [7:0]  res_filter,
  output logic [7:0]  res_row,
  output logic [7:0]  res_col,
  output logic        busy,
  output logic        done
);

  localparam int OUT_DIM = (IMG_SIZE - FILTER_SIZE) / STRIDE + 1;
  localparam int TAPS    = FILTER_SIZE * FILTER_SIZE;
  localparam int KW      = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam int IW      = (IMG_SIZE * IMG_SIZE > 1) ? $clog2(IMG_SIZE * IMG_SIZE) : 1;
  localparam int FW      = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1;

  localparam logic [KW-1:0] LAST_K  = KW'(TAPS - 1);
  localparam logic [7:0]    LAST_RC = 8'(OUT_DIM - 1);
  localparam logic [7:0]    LAST_F  = 8'(NUM_FILTERS - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MAC  = 2'd1;
  localparam logic [1:0] S_OUT  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]    state;
  logic [19:0]   acc;
  logic [7:0]    f;
  logic [7:0]    r;
  logic [7:0]    c;
  logic [KW-1:0] k;

  int            tap_row;
  int            tap_col;
  logic [IW-1:0] pix_idx;
  logic [15:0]   prod;
  logic [19:0]   sum;
  logic [19:0]   res_next;
  logic          last_result;

  // Address the current window pixel/tap pair and form the next accumulator value.
  always_comb begin
    tap_row  = 32'(k) / FILTER_SIZE;
    tap_col  = 32'(k) % FILTER_SIZE;
    pix_idx  = IW'((32'(r) * STRIDE + tap_row) * IMG_SIZE + 32'(c) * STRIDE + tap_col);
    prod     = 16'(img_data[pix_idx]) * 16'(filters[f[FW-1:0]][k]);
    sum      = acc + 20'(prod);
`ifdef CONV_SATURATE_EN
    if (sum > 20'd255) begin
      res_next = 20'd255;
    end else begin
      res_next = sum;
    end
`else
    res_next = sum;
`endif
    if ((f == LAST_F) && (r == LAST_RC) && (c == LAST_RC)) begin
      last_result = 1'b1;
    end else begin
      last_result = 1'b0;
    end
  end

  // Control FSM, window/filter counters, accumulator and registered result port.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      acc        <= 20'd0;
      f          <= 8'd0;
      r          <= 8'd0;
      c          <= 8'd0;
      k          <= '0;
      res_valid  <= 1'b0;
      res_data   <= 20'd0;
      res_filter <= 8'd0;
      res_row    <= 8'd0;
      res_col    <= 8'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            state <= S_MAC;
            busy  <= 1'b1;
            acc   <= 20'd0;
            f     <= 8'd0;
            r     <= 8'd0;
            c     <= 8'd0;
            k     <= '0;
          end
        end
        S_MAC: begin
          acc <= sum;
          if (k == LAST_K) begin
            // Final tap: capture the completed sum and its indices for the port.
            state      <= S_OUT;
            res_valid  <= 1'b1;
            res_data   <= res_next;
            res_filter <= f;
            res_row    <= r;
            res_col    <= c;
          end else begin
            k <= k + KW'(1);
          end
        end
        S_OUT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            acc       <= 20'd0;
            k         <= '0;
            if (last_result) begin
              state <= S_DONE;
              done  <= 1'b1;
              f     <= 8'd0;
              r     <= 8'd0;
              c     <= 8'd0;
            end else begin
              state <= S_MAC;
              if (c == LAST_RC) begin
                c <= 8'd0;
                if (r == LAST_RC) begin
                  r <= 8'd0;
                  f <= f + 8'd1;
                end else begin
                  r <= r + 8'd1;
                end
              end else begin
                c <= c + 8'd1;
              end
            end
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          state     <= S_IDLE;
          res_valid <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv_mac_engine.sv
`timescale 1ns/1ps
// Directed bench for conv_mac_engine with a result scoreboard.
module tb_conv_mac_engine;

  localparam int IS = 16;
  localparam int FS = 4;
  localparam int NF = 4;
  localparam int ST = 1;
  localparam int OD = (IS - FS) / ST + 1;
  localparam int NRES = NF * OD * OD;

  typedef struct {
    logic [19:0] d;
    logic [7:0]  f;
    logic [7:0]  r;
    logic [7:0]  c;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  img  [IS*IS];
  logic [7:0]  filt [NF][FS*FS];
  logic        res_ready = 1'b1;
  logic        res_valid;
  logic [19:0] res_data;
  logic [7:0]  res_filter, res_row, res_col;
  logic        busy, done;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail = 0;
  logic [19:0] got37;
  logic [19:0] first_data;

  conv_mac_engine #(.IMG_SIZE(IS), .FILTER_SIZE(FS), .NUM_FILTERS(NF), .STRIDE(ST)) dut (
    .clk(clk), .rst(rst), .start(start), .img_data(img), .filters(filt),
    .res_ready(res_ready), .res_valid(res_valid), .res_data(res_data),
    .res_filter(res_filter), .res_row(res_row), .res_col(res_col),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [19:0] ref_conv(input int fi, input int ri, input int ci);
    int s = 0;
    for (int i = 0; i < FS; i++)
      for (int j = 0; j < FS; j++)
        s += int'(img[(ri*ST + i)*IS + ci*ST + j]) * int'(filt[fi][i*FS + j]);
`ifdef CONV_SATURATE_EN
    if (s > 255) s = 255;
`endif
    return 20'(s);
  endfunction

  task automatic push_all();
    exp_t e;
    for (int fi = 0; fi < NF; fi++)
      for (int ri = 0; ri < OD; ri++)
        for (int ci = 0; ci < OD; ci++) begin
          e.d = ref_conv(fi, ri, ci);
          e.f = 8'(fi); e.r = 8'(ri); e.c = 8'(ci);
          sb.push_back(e);
        end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    start = 1'b0;
    res_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    sb.delete();
  endtask

  task automatic kick();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Run after kick(): cycle 1 is the first negedge after the start edge.
  task automatic run(input int budget, input int max_res, input int stall_n, input int pulse_cyc,
                     output int first_v, output int done_c, output int nres,
                     output int onset2, output int acc1);
    int cyc = 0;
    bit newv = 1'b1;
    int stall_left = stall_n;
    bit have_hold = 1'b0;
    logic [19:0] hd;
    logic [7:0] hf, hr, hc;
    exp_t e;
    first_v = -1; done_c = -1; nres = 0; onset2 = -1; acc1 = -1;
    while (cyc < budget) begin
      @(negedge clk);
      cyc++;
      start = (cyc == pulse_cyc);
      if (cyc == 1) check("busy_cycle1", 32'(busy), 32'd1);
      if (done) begin
        done_c = cyc;
        break;
      end
      if (res_valid) begin
        if (newv) begin
          if (nres == 0) first_v = cyc;
          else if (nres == 1) onset2 = cyc;
          newv = 1'b0;
        end
        if (stall_left > 0 && nres == 0) begin
          if (!have_hold) begin
            hd = res_data; hf = res_filter; hr = res_row; hc = res_col;
            have_hold = 1'b1;
          end else begin
            check("stall_valid", 32'(res_valid), 32'd1);
            check("stall_data", 32'(res_data), 32'(hd));
            check("stall_idx", {8'd0, res_filter, res_row, res_col}, {8'd0, hf, hr, hc});
          end
          res_ready = 1'b0;
          stall_left--;
        end else begin
          res_ready = 1'b1;
          if (sb.size() == 0) begin
            check("extra_result", 32'(nres), 32'(NRES));
          end else begin
            e = sb.pop_front();
            check("res_data", 32'(res_data), 32'(e.d));
            check("res_idx", {8'd0, res_filter, res_row, res_col}, {8'd0, e.f, e.r, e.c});
            if (e.f == 8'd0 && e.r == 8'd2 && e.c == 8'd5) got37 = res_data;
          end
          if (nres == 0) first_data = res_data;
          nres++;
          if (nres == 1) acc1 = cyc;
          newv = 1'b1;
          if (nres == max_res) break;
        end
      end else begin
        res_ready = 1'b1;
      end
    end
    start = 1'b0;
  endtask

  initial begin
    int fv, dc, nr, o2, a1;
    logic [19:0] exp_big;
    // ---- reset values ----
    for (int i = 0; i < IS*IS; i++) img[i] = 8'd1;
    for (int fi = 0; fi < NF; fi++)
      for (int t = 0; t < FS*FS; t++) filt[fi][t] = 8'd1;
    do_reset();
    @(negedge clk);
    check("rst_valid", 32'(res_valid), 32'd0);
    check("rst_data", 32'(res_data), 32'd0);
    check("rst_idx", {8'd0, res_filter, res_row, res_col}, 32'd0);
    check("rst_busy_done", {30'd0, busy, done}, 32'd0);

    // ---- T1: all ones, full run ----
    push_all();
    kick();
    run(12000, NRES + 1, 0, -1, fv, dc, nr, o2, a1);
    check("t1_first_valid", 32'(fv), 32'd17);
    check("t1_second_valid", 32'(o2), 32'd34);
    check("t1_count", 32'(nr), 32'(NRES));
    check("t1_first_data", 32'(first_data), 32'd16);
    check("t1_done_cycle", 32'(dc), 32'd11493);
    check("t1_sb_empty", 32'(sb.size()), 32'd0);
    @(negedge clk);
    check("t1_busy_after", 32'(busy), 32'd0);
    check("t1_done_pulse", 32'(done), 32'd0);

    // ---- T2: ramp image, filter 0 picks tap 0, others random ----
    for (int i = 0; i < IS*IS; i++) img[i] = 8'(i);
    for (int t = 0; t < FS*FS; t++) filt[0][t] = (t == 0) ? 8'd1 : 8'd0;
    for (int fi = 1; fi < NF; fi++)
      for (int t = 0; t < FS*FS; t++) filt[fi][t] = 8'($urandom_range(0, 255));
    got37 = 20'd0;
    push_all();
    kick();
    run(12000, NRES + 1, 0, -1, fv, dc, nr, o2, a1);
    check("t2_count", 32'(nr), 32'(NRES));
    check("t2_pix_2_5", 32'(got37), 32'd37);
    check("t2_done_cycle", 32'(dc), 32'd11493);

    // ---- T3: all 255, a few results then abort ----
    for (int i = 0; i < IS*IS; i++) img[i] = 8'd255;
    for (int fi = 0; fi < NF; fi++)
      for (int t = 0; t < FS*FS; t++) filt[fi][t] = 8'd255;
`ifdef CONV_SATURATE_EN
    exp_big = 20'd255;
`else
    exp_big = 20'd1040400;
`endif
    push_all();
    kick();
    run(200, 3, 0, -1, fv, dc, nr, o2, a1);
    check("t3_count", 32'(nr), 32'd3);
    check("t3_max_data", 32'(first_data), 32'(exp_big));
    do_reset();

    // ---- T4: hold res_ready low 5 cycles on first result ----
    for (int i = 0; i < IS*IS; i++) img[i] = 8'(i * 3 + 7);
    for (int fi = 0; fi < NF; fi++)
      for (int t = 0; t < FS*FS; t++) filt[fi][t] = 8'(fi + t);
    push_all();
    kick();
    run(200, 2, 5, -1, fv, dc, nr, o2, a1);
    check("t4_first_valid", 32'(fv), 32'd17);
    check("t4_accept_cycle", 32'(a1), 32'd22);
    check("t4_second_valid", 32'(o2), 32'(a1 + 17));
    do_reset();

    // ---- T5: stray start pulse mid-run is ignored ----
    for (int i = 0; i < IS*IS; i++) img[i] = 8'd1;
    for (int fi = 0; fi < NF; fi++)
      for (int t = 0; t < FS*FS; t++) filt[fi][t] = 8'd1;
    push_all();
    kick();
    run(12000, NRES + 1, 0, 50, fv, dc, nr, o2, a1);
    check("t5_count", 32'(nr), 32'(NRES));
    check("t5_done_cycle", 32'(dc), 32'd11493);
    @(negedge clk);
    check("t5_busy_after", 32'(busy), 32'd0);

    // ---- T6: reset in cycle 30, then restart ----
    kick();
    repeat (30) @(negedge clk);
    check("t6_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t6_valid", 32'(res_valid), 32'd0);
    check("t6_data", 32'(res_data), 32'd0);
    check("t6_idx", {8'd0, res_filter, res_row, res_col}, 32'd0);
    check("t6_busy_done", {30'd0, busy, done}, 32'd0);
    push_all();
    kick();
    run(200, 1, 0, -1, fv, dc, nr, o2, a1);
    check("t6_first_valid", 32'(fv), 32'd17);
    check("t6_first_data", 32'(first_data), 32'd16);
    do_reset();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
